// File: rtl/bb_lcd_static_drv_pkg.sv
// Segment bit map and digit patterns shared by the static LCD driver and its decoder.
package bb_lcd_static_drv_pkg;

    typedef logic [6:0] seg_pat_t;
    typedef logic [3:0] bcd_t;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    function automatic seg_pat_t seg_mask(
        input bit a, input bit b, input bit c, input bit d,
        input bit e, input bit f, input bit g
    );
        seg_pat_t m;
        m        = '0;
        m[SEG_A] = a;
        m[SEG_B] = b;
        m[SEG_C] = c;
        m[SEG_D] = d;
        m[SEG_E] = e;
        m[SEG_F] = f;
        m[SEG_G] = g;
        return m;
    endfunction

    localparam seg_pat_t PAT_0    = seg_mask(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    localparam seg_pat_t PAT_1    = seg_mask(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    localparam seg_pat_t PAT_2    = seg_mask(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    localparam seg_pat_t PAT_3    = seg_mask(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    localparam seg_pat_t PAT_4    = seg_mask(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    localparam seg_pat_t PAT_5    = seg_mask(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    localparam seg_pat_t PAT_6    = seg_mask(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    localparam seg_pat_t PAT_7    = seg_mask(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    localparam seg_pat_t PAT_8    = seg_mask(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    localparam seg_pat_t PAT_9    = seg_mask(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    localparam seg_pat_t PAT_DASH = seg_mask(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

endpackage

// File: rtl/bb_lcd_static_drv_if.sv
// Digit inputs and glass pins of the static LCD driver; slave is the driver side.
interface bb_lcd_static_drv_if #(
    parameter int NDIG = 2
);
    logic [4*NDIG-1:0] bcd_in;
    logic [NDIG-1:0]   dp_in;
    logic              blank_lz;
    logic              lcd_bp;
    logic [7*NDIG-1:0] lcd_seg;
    logic [NDIG-1:0]   lcd_dp;
    logic              frame_tick;

    modport master (
        output bcd_in, dp_in, blank_lz,
        input  lcd_bp, lcd_seg, lcd_dp, frame_tick
    );

    modport slave (
        input  bcd_in, dp_in, blank_lz,
        output lcd_bp, lcd_seg, lcd_dp, frame_tick
    );
endinterface

// File: rtl/bb_seg7_dec.sv
// Combinational BCD to 7-segment decoder; codes 10-15 show a dash.
module bb_seg7_dec
    import bb_lcd_static_drv_pkg::*;
(
    input  bcd_t     bcd,
    output seg_pat_t seg
);

    always_comb begin
        seg = PAT_DASH;
        case (bcd)
            4'd0:    seg = PAT_0;
            4'd1:    seg = PAT_1;
            4'd2:    seg = PAT_2;
            4'd3:    seg = PAT_3;
            4'd4:    seg = PAT_4;
            4'd5:    seg = PAT_5;
            4'd6:    seg = PAT_6;
            4'd7:    seg = PAT_7;
            4'd8:    seg = PAT_8;
            4'd9:    seg = PAT_9;
            default: seg = PAT_DASH;
        endcase
    end

endmodule

// File: rtl/bb_lcd_static_drv.sv
// Static LCD driver: BCD digits to 7-segment glass, every pin XORed with the
// backplane square wave so the panel never sees DC. Inputs sampled once per frame.
module bb_lcd_static_drv
    import bb_lcd_static_drv_pkg::*;
#(
    parameter int NDIG = 2,
    parameter int DIV  = 16
) (
    input  logic               clk,
    input  logic               nrst,
    bb_lcd_static_drv_if.slave bus
);

    localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(DIV - 1);
    localparam int            NSEG     = 7 * NDIG;

    logic [PW-1:0]     presc;
    logic              bp_q;
    logic [4*NDIG-1:0] bcd_sh_p0;
    logic [NDIG-1:0]   dp_sh_p0;
    logic              blank_sh_p0;
    logic [NSEG-1:0]   seg_p1;
    logic [NDIG-1:0]   dp_p1;
    logic              vld_p1;

    logic              toggle;
    logic              frame_edge;
    logic [4*NDIG-1:0] bcd_src;
    logic [NDIG-1:0]   dp_src;
    logic              blank_src;
    logic [NDIG-1:0]   blank_dig;
    logic [NSEG-1:0]   pat_raw;
    logic [NSEG-1:0]   pat;

    assign toggle     = (presc == PRESC_TC);
    assign frame_edge = toggle & bp_q;

    // On the frame edge the outputs must already show the values being latched.
    assign bcd_src   = frame_edge ? bus.bcd_in   : bcd_sh_p0;
    assign dp_src    = frame_edge ? bus.dp_in    : dp_sh_p0;
    assign blank_src = frame_edge ? bus.blank_lz : blank_sh_p0;

    always_comb begin
        logic run;
        run       = 1'b1;
        blank_dig = '0;
        for (int d = NDIG - 1; d >= 1; d--) begin
            run          = run & (bcd_src[4*d +: 4] == 4'd0);
            blank_dig[d] = blank_src & run;
        end
    end

    for (genvar d = 0; d < NDIG; d++) begin : g_dig
        bb_seg7_dec u_dec (
            .bcd (bcd_src[4*d +: 4]),
            .seg (pat_raw[7*d +: 7])
        );
        assign pat[7*d +: 7] = blank_dig[d] ? 7'd0 : pat_raw[7*d +: 7];
    end

    // Stage p0: prescaler, backplane and shadow registers; stage p1: pin registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            presc       <= '0;
            bp_q        <= 1'b0;
            bcd_sh_p0   <= '0;
            dp_sh_p0    <= '0;
            blank_sh_p0 <= 1'b0;
            seg_p1      <= '0;
            dp_p1       <= '0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= frame_edge;
            presc  <= toggle ? '0 : presc + PW'(1);
            if (frame_edge) begin
                bcd_sh_p0   <= bus.bcd_in;
                dp_sh_p0    <= bus.dp_in;
                blank_sh_p0 <= bus.blank_lz;
            end
            if (toggle) begin
                bp_q   <= ~bp_q;
                seg_p1 <= pat ^ {NSEG{~bp_q}};
                dp_p1  <= dp_src ^ {NDIG{~bp_q}};
            end
        end
    end

    assign bus.lcd_bp     = bp_q;
    assign bus.lcd_seg    = seg_p1;
    assign bus.lcd_dp     = dp_p1;
    assign bus.frame_tick = vld_p1;

endmodule

// File: tb/tb_bb_lcd_static_drv.sv
// Bench for bb_lcd_static_drv (NDIG=2, DIV=16): vector table, directed corner
// sequences and random inputs against a cycle-count based display model.
module tb_bb_lcd_static_drv;

    localparam int NDIG = 2;
    localparam int DIV  = 16;
    localparam int NSEG = 7 * NDIG;

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    bb_lcd_static_drv_if #(.NDIG(NDIG)) bus ();

    bb_lcd_static_drv #(.NDIG(NDIG), .DIV(DIV)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    typedef struct {
        logic [7:0]  bcd;
        logic [1:0]  dp;
        logic        blank;
        logic [13:0] pat;
        logic [1:0]  dpo;
    } vec_t;

    vec_t       vecs [10];
    logic [6:0] digit_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: clocks since reset release plus the inputs seen at the last frame edge.
    int          k = 0;
    logic [7:0]  m_bcd   = '0;
    logic [1:0]  m_dp    = '0;
    logic        m_blank = 1'b0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NSEG-1:0] ref_pattern(input logic [7:0] bcd, input logic blank);
        logic [NSEG-1:0] p;
        int v;
        p = '0;
        for (int d = 0; d < NDIG; d++) begin
            v = int'(bcd[4*d +: 4]);
            if (!(blank && d > 0 && (bcd >> (4*d)) == 8'd0))
                p[7*d +: 7] = (v < 10) ? digit_tbl[v] : 7'h40;
        end
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        k++;
        if (k % (2*DIV) == 0) begin
            m_bcd   = bus.bcd_in;
            m_dp    = bus.dp_in;
            m_blank = bus.blank_lz;
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        k       = 0;
        m_bcd   = '0;
        m_dp    = '0;
        m_blank = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic        e_bp;
        logic [13:0] e_seg;
        logic [1:0]  e_dp;
        logic        e_tick;
        e_bp = ((k / DIV) % 2) == 1;
        if (k < DIV) begin
            e_seg = '0;
            e_dp  = '0;
        end else begin
            e_seg = ref_pattern(m_bcd, m_blank) ^ {NSEG{e_bp}};
            e_dp  = m_dp ^ {NDIG{e_bp}};
        end
        e_tick = (k > 0) && (k % (2*DIV) == 0);
        cmp({tag, "_bp"},   32'(bus.lcd_bp),     32'(e_bp));
        cmp({tag, "_seg"},  32'(bus.lcd_seg),    32'(e_seg));
        cmp({tag, "_dp"},   32'(bus.lcd_dp),     32'(e_dp));
        cmp({tag, "_tick"}, 32'(bus.frame_tick), 32'(e_tick));
    endtask

    task automatic check_zero(input string tag);
        cmp({tag, "_bp"},   32'(bus.lcd_bp),     32'd0);
        cmp({tag, "_seg"},  32'(bus.lcd_seg),    32'd0);
        cmp({tag, "_dp"},   32'(bus.lcd_dp),     32'd0);
        cmp({tag, "_tick"}, 32'(bus.frame_tick), 32'd0);
    endtask

    task automatic to_frame_edge();
        for (int i = 0; i < 2*DIV; i++) begin
            step();
            if (k % (2*DIV) == 0) break;
        end
        cmp("frame_sync", 32'(k % (2*DIV)), 32'd0);
    endtask

    task automatic randomize_inputs();
        bus.bcd_in   = 8'($urandom);
        bus.dp_in    = 2'($urandom);
        bus.blank_lz = 1'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [13:0] e14;
        int          hi_bp;
        int          hi_seg [NSEG];
        int          hi_dp [NDIG];
        int          ticks;

        vecs[0] = '{8'h00, 2'b00, 1'b0, {7'h3F, 7'h3F}, 2'b00};
        vecs[1] = '{8'h42, 2'b00, 1'b0, {7'h66, 7'h5B}, 2'b00};
        vecs[2] = '{8'h07, 2'b00, 1'b1, {7'h00, 7'h07}, 2'b00};
        vecs[3] = '{8'h00, 2'b00, 1'b1, {7'h00, 7'h3F}, 2'b00};
        vecs[4] = '{8'hC3, 2'b10, 1'b0, {7'h40, 7'h4F}, 2'b10};
        vecs[5] = '{8'h95, 2'b00, 1'b1, {7'h6F, 7'h6D}, 2'b00};
        vecs[6] = '{8'h0F, 2'b10, 1'b1, {7'h00, 7'h40}, 2'b10};
        vecs[7] = '{8'hA0, 2'b01, 1'b1, {7'h40, 7'h3F}, 2'b01};
        vecs[8] = '{8'h81, 2'b11, 1'b0, {7'h7F, 7'h06}, 2'b11};
        vecs[9] = '{8'h36, 2'b00, 1'b0, {7'h4F, 7'h7D}, 2'b00};

        bus.bcd_in   = 8'h00;
        bus.dp_in    = 2'b00;
        bus.blank_lz = 1'b0;

        // Reset and release.
        #1 nrst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        nrst = 1'b1;
        model_reset();
        for (int i = 0; i < DIV - 1; i++) step();
        check_model("pre_toggle");
        step();
        cmp("first_toggle_bp", 32'(bus.lcd_bp), 32'd1);
        cmp("first_toggle_d0", 32'(bus.lcd_seg[6:0]), 32'h40);

        // Change in the middle of a bp-low half.
        to_frame_edge();
        repeat (5) step();
        bus.bcd_in = 8'h42;
        repeat (DIV - 5) step();
        e14 = ~{7'h3F, 7'h3F};
        cmp("mid_rise_bp",  32'(bus.lcd_bp),  32'd1);
        cmp("mid_rise_seg", 32'(bus.lcd_seg), 32'(e14));
        repeat (DIV - 1) step();
        cmp("mid_pre_tick", 32'(bus.frame_tick), 32'd0);
        cmp("mid_pre_seg",  32'(bus.lcd_seg),    32'(e14));
        step();
        cmp("mid_fe_bp",   32'(bus.lcd_bp),        32'd0);
        cmp("mid_fe_d0",   32'(bus.lcd_seg[6:0]),  32'h5B);
        cmp("mid_fe_d1",   32'(bus.lcd_seg[13:7]), 32'h66);
        cmp("mid_fe_tick", 32'(bus.frame_tick),    32'd1);
        step();
        cmp("mid_post_tick", 32'(bus.frame_tick), 32'd0);

        // Vector table: values at the frame edge and in the following bp-high half.
        foreach (vecs[i]) begin
            bus.bcd_in   = vecs[i].bcd;
            bus.dp_in    = vecs[i].dp;
            bus.blank_lz = vecs[i].blank;
            to_frame_edge();
            cmp($sformatf("vec%0d_bp_lo", i),  32'(bus.lcd_bp),     32'd0);
            cmp($sformatf("vec%0d_seg_lo", i), 32'(bus.lcd_seg),    32'(vecs[i].pat));
            cmp($sformatf("vec%0d_dp_lo", i),  32'(bus.lcd_dp),     32'(vecs[i].dpo));
            cmp($sformatf("vec%0d_tick", i),   32'(bus.frame_tick), 32'd1);
            repeat (DIV) step();
            e14 = ~vecs[i].pat;
            cmp($sformatf("vec%0d_bp_hi", i),  32'(bus.lcd_bp),  32'd1);
            cmp($sformatf("vec%0d_seg_hi", i), 32'(bus.lcd_seg), 32'(e14));
            cmp($sformatf("vec%0d_dp_hi", i),  32'(bus.lcd_dp),  32'(2'(~vecs[i].dpo)));
        end

        // DC balance over ten backplane periods with static inputs.
        randomize_inputs();
        to_frame_edge();
        hi_bp = 0;
        ticks = 0;
        foreach (hi_seg[j]) hi_seg[j] = 0;
        foreach (hi_dp[j]) hi_dp[j] = 0;
        for (int c = 0; c < 20*DIV; c++) begin
            step();
            check_model("dc");
            hi_bp += int'(bus.lcd_bp);
            ticks += int'(bus.frame_tick);
            foreach (hi_seg[j]) hi_seg[j] += int'(bus.lcd_seg[j]);
            foreach (hi_dp[j]) hi_dp[j] += int'(bus.lcd_dp[j]);
        end
        cmp("dc_bp", 32'(hi_bp), 32'(10*DIV));
        foreach (hi_seg[j]) cmp($sformatf("dc_seg%0d", j), 32'(hi_seg[j]), 32'(10*DIV));
        foreach (hi_dp[j]) cmp($sformatf("dc_dp%0d", j), 32'(hi_dp[j]), 32'(10*DIV));
        cmp("dc_ticks", 32'(ticks), 32'd10);

        // Random input changes at arbitrary times.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) randomize_inputs();
            step();
            check_model("rand");
        end

        // Asynchronous reset with bp high and prescaler at 7.
        for (int i = 0; i < 2*DIV; i++) begin
            if (k % (2*DIV) == DIV + 7) break;
            step();
        end
        cmp("rst_mid_bp_before", 32'(bus.lcd_bp), 32'd1);
        #2 nrst = 1'b0;
        #1 check_zero("rst_mid_async");
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("rst_mid_hold");
        randomize_inputs();
        nrst = 1'b1;
        for (int i = 0; i < DIV - 1; i++) begin
            step();
            check_model("rst_rel");
        end
        step();
        check_model("rst_first_toggle");
        cmp("rst_first_toggle_bp", 32'(bus.lcd_bp), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
